// File: rtl/i2c_temp_target.sv
// I2C target exposing a temperature snapshot, a config register and a device ID.
// SCL/SDA are synchronized and glitch-filtered; all bus events use filtered levels.
module i2c_temp_target #(
   parameter logic [6:0] DEV_ADDR = 7'h4B,
   parameter int         FILT_LEN = 3,
   parameter logic [7:0] DEV_ID   = 8'hCB
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic [15:0] temp_data,
   output logic [7:0]  config_reg,
   output logic        busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, WR_DATA,
      W_ACK, RD_DATA, RD_ACK, IGNORE
   } state_t;

   logic [1:0]          r_scl_sync, r_sda_sync;
   logic [FILT_LEN-2:0] r_scl_hist, r_sda_hist;
   logic [FILT_LEN-1:0] w_scl_win, w_sda_win;
   logic                r_scl_f, r_sda_f, r_scl_d, r_sda_d;

   assign w_scl_win = {r_scl_hist, r_scl_sync[1]};
   assign w_sda_win = {r_sda_hist, r_sda_sync[1]};

   // A new level is accepted only once the whole window agrees
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_hist <= '1;
         r_sda_hist <= '1;
         r_scl_f    <= 1'b1;
         r_sda_f    <= 1'b1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[0], scl_in};
         r_sda_sync <= {r_sda_sync[0], sda_in};
         r_scl_hist <= w_scl_win[FILT_LEN-2:0];
         r_sda_hist <= w_sda_win[FILT_LEN-2:0];
         if (&w_scl_win)       r_scl_f <= 1'b1;
         else if (~|w_scl_win) r_scl_f <= 1'b0;
         if (&w_sda_win)       r_sda_f <= 1'b1;
         else if (~|w_sda_win) r_sda_f <= 1'b0;
         r_scl_d    <= r_scl_f;
         r_sda_d    <= r_sda_f;
      end
   end

   logic w_scl_rise, w_scl_fall, w_start, w_stop;

   assign w_scl_rise = r_scl_f & ~r_scl_d;
   assign w_scl_fall = ~r_scl_f & r_scl_d;
   assign w_start    = r_scl_f & r_sda_d & ~r_sda_f;
   assign w_stop     = r_scl_f & ~r_sda_d & r_sda_f;

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_bitcnt, w_cnt_nxt;
   logic [6:0]  r_shift, w_shift_nxt;
   logic [3:0]  r_ptr, w_ptr_nxt;
   logic [7:0]  r_cfg, w_cfg_nxt;
   logic [15:0] r_shadow, w_shadow_nxt;
   logic [7:0]  r_tx, w_tx_nxt;
   logic        r_oe, w_oe_nxt;
   logic        r_busy, w_busy_nxt;
   logic        r_rw, w_rw_nxt;
   logic        r_acked, w_acked_nxt;

   logic [7:0]  w_byte, w_rd;
   logic [2:0]  w_idx;
   logic        w_last;

   assign w_byte = {r_shift, r_sda_f};
   assign w_last = (r_bitcnt == 3'd7);
   assign w_idx  = 3'd7 - r_bitcnt;

   always_comb begin
      w_rd = 8'h00;
      case (r_ptr)
         4'h0:    w_rd = r_shadow[15:8];
         4'h1:    w_rd = r_shadow[7:0];
         4'h3:    w_rd = r_cfg;
         4'hB:    w_rd = DEV_ID;
         default: w_rd = 8'h00;
      endcase
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_bitcnt;
      w_shift_nxt  = r_shift;
      w_ptr_nxt    = r_ptr;
      w_cfg_nxt    = r_cfg;
      w_shadow_nxt = r_shadow;
      w_tx_nxt     = r_tx;
      w_oe_nxt     = r_oe;
      w_busy_nxt   = r_busy;
      w_rw_nxt     = r_rw;
      w_acked_nxt  = r_acked;
      if (w_stop) begin
         w_state_nxt = IDLE;
         w_oe_nxt    = 1'b0;
         w_busy_nxt  = 1'b0;
      end else if (w_start) begin
         w_state_nxt = ADDR;
         w_cnt_nxt   = 3'd0;
         w_oe_nxt    = 1'b0;
         w_busy_nxt  = 1'b1;
      end else begin
         unique case (r_state)
            ADDR, PTR, WR_DATA: begin
               if (w_scl_rise) begin
                  w_shift_nxt = w_byte[6:0];
                  w_cnt_nxt   = r_bitcnt + 3'd1;
                  if (w_last) begin
                     if (r_state == ADDR) begin
                        if (w_byte[7:1] == DEV_ADDR) begin
                           w_state_nxt = ADDR_ACK;
                           w_rw_nxt    = w_byte[0];
                           if (w_byte[0]) w_shadow_nxt = temp_data;
                        end else begin
                           w_state_nxt = IGNORE;
                        end
                     end else if (r_state == PTR) begin
                        w_ptr_nxt   = w_byte[3:0];
                        w_state_nxt = W_ACK;
                     end else begin
                        if (r_ptr == 4'h3) w_cfg_nxt = w_byte;
                        w_ptr_nxt   = r_ptr + 4'd1;
                        w_state_nxt = W_ACK;
                     end
                  end
               end
            end
            ADDR_ACK: begin
               if (w_scl_fall) begin
                  if (!r_oe) begin
                     w_oe_nxt = 1'b1;
                  end else if (r_rw) begin
                     w_state_nxt = RD_DATA;
                     w_tx_nxt    = w_rd;
                     w_oe_nxt    = ~w_rd[7];
                     w_cnt_nxt   = 3'd1;
                  end else begin
                     w_state_nxt = PTR;
                     w_oe_nxt    = 1'b0;
                     w_cnt_nxt   = 3'd0;
                  end
               end
            end
            W_ACK: begin
               if (w_scl_fall) begin
                  if (!r_oe) begin
                     w_oe_nxt = 1'b1;
                  end else begin
                     w_state_nxt = WR_DATA;
                     w_oe_nxt    = 1'b0;
                     w_cnt_nxt   = 3'd0;
                  end
               end
            end
            RD_DATA: begin
               // Count 0 here means all eight bits have been clocked out
               if (w_scl_fall) begin
                  if (r_bitcnt == 3'd0) begin
                     w_state_nxt = RD_ACK;
                     w_oe_nxt    = 1'b0;
                     w_acked_nxt = 1'b0;
                  end else begin
                     w_oe_nxt  = ~r_tx[w_idx];
                     w_cnt_nxt = r_bitcnt + 3'd1;
                  end
               end
            end
            RD_ACK: begin
               if (w_scl_rise) begin
                  w_ptr_nxt = r_ptr + 4'd1;
                  if (r_sda_f) w_state_nxt = IGNORE;
                  else         w_acked_nxt = 1'b1;
               end else if (w_scl_fall && r_acked) begin
                  w_state_nxt = RD_DATA;
                  w_tx_nxt    = w_rd;
                  w_oe_nxt    = ~w_rd[7];
                  w_cnt_nxt   = 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_bitcnt <= 3'd0;
         r_shift  <= 7'd0;
         r_ptr    <= 4'h0;
         r_cfg    <= 8'h00;
         r_shadow <= 16'h0000;
         r_tx     <= 8'h00;
         r_oe     <= 1'b0;
         r_busy   <= 1'b0;
         r_rw     <= 1'b0;
         r_acked  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_bitcnt <= w_cnt_nxt;
         r_shift  <= w_shift_nxt;
         r_ptr    <= w_ptr_nxt;
         r_cfg    <= w_cfg_nxt;
         r_shadow <= w_shadow_nxt;
         r_tx     <= w_tx_nxt;
         r_oe     <= w_oe_nxt;
         r_busy   <= w_busy_nxt;
         r_rw     <= w_rw_nxt;
         r_acked  <= w_acked_nxt;
      end
   end

   assign sda_oe     = r_oe;
   assign config_reg = r_cfg;
   assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_temp_target.sv
// Directed bench for i2c_temp_target: a bit-banged host on an
// open-drain bus model, with hand-computed expected bytes and ACKs.
module tb_i2c_temp_target;

   localparam int Q = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        scl_h = 1'b1;
   logic        sda_h = 1'b1;
   logic [15:0] temp_data = 16'h0C80;
   logic        sda_oe;
   logic [7:0]  config_reg;
   logic        busy;
   logic        sda_bus;

   int n_chk  = 0;
   int n_pass = 0;

   assign sda_bus = sda_h & ~sda_oe;

   always #5 clk = ~clk;

   i2c_temp_target dut (
      .clk       (clk),
      .rst       (rst),
      .scl_in    (scl_h),
      .sda_in    (sda_bus),
      .sda_oe    (sda_oe),
      .temp_data (temp_data),
      .config_reg(config_reg),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic qw();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_h = 1'b1; qw();
      scl_h = 1'b1; qw();
      sda_h = 1'b0; qw();
      scl_h = 1'b0; qw();
   endtask

   task automatic i2c_stop();
      sda_h = 1'b0; qw();
      scl_h = 1'b1; qw();
      sda_h = 1'b1; qw();
      qw();
   endtask

   task automatic clk_bit(input logic b, output logic s);
      sda_h = b;    qw();
      scl_h = 1'b1; qw();
      s = sda_bus;  qw();
      scl_h = 1'b0; qw();
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
      clk_bit(1'b1, ack);
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, s);
         d[i] = s;
      end
      clk_bit(nack, s);
   endtask

   initial begin
      logic       ack;
      logic [7:0] d;

      repeat (5) @(negedge clk);
      check("rst_oe",   {15'd0, sda_oe}, 16'h0);
      check("rst_busy", {15'd0, busy},   16'h0);
      check("rst_cfg",  {8'd0, config_reg}, 16'h00);
      rst = 1'b1;
      qw();

      // Temperature read with repeated start and mid-read temp change
      i2c_start();
      check("t1_busy", {15'd0, busy}, 16'h1);
      wr_byte(8'h96, ack); check("t1_ack_w", {15'd0, ack}, 16'h0);
      wr_byte(8'h00, ack); check("t1_ack_p", {15'd0, ack}, 16'h0);
      i2c_start();
      wr_byte(8'h97, ack); check("t1_ack_r", {15'd0, ack}, 16'h0);
      rd_byte(1'b0, d);    check("t1_msb", {8'd0, d}, 16'h0C);
      temp_data = 16'h0D00;
      rd_byte(1'b1, d);    check("t1_lsb", {8'd0, d}, 16'h80);
      check("t1_rel", {15'd0, sda_oe}, 16'h0);
      i2c_stop();
      check("t1_idle", {15'd0, busy}, 16'h0);

      // Config write then readback
      i2c_start();
      wr_byte(8'h96, ack); check("t2_ack_w", {15'd0, ack}, 16'h0);
      wr_byte(8'h03, ack); check("t2_ack_p", {15'd0, ack}, 16'h0);
      wr_byte(8'hA0, ack); check("t2_ack_d", {15'd0, ack}, 16'h0);
      i2c_stop();
      check("t2_cfg", {8'd0, config_reg}, 16'hA0);
      i2c_start();
      wr_byte(8'h96, ack);
      wr_byte(8'h03, ack);
      i2c_start();
      wr_byte(8'h97, ack); check("t2_ack_r", {15'd0, ack}, 16'h0);
      rd_byte(1'b1, d);    check("t2_rd", {8'd0, d}, 16'hA0);
      i2c_stop();

      // Address mismatch, then a matching read header (pointer now 0x04)
      i2c_start();
      check("t3_busy", {15'd0, busy}, 16'h1);
      wr_byte(8'h90, ack); check("t3_nack", {15'd0, ack}, 16'h1);
      check("t3_oe", {15'd0, sda_oe}, 16'h0);
      i2c_start();
      wr_byte(8'h97, ack); check("t3_ack_r", {15'd0, ack}, 16'h0);
      check("t3_busy2", {15'd0, busy}, 16'h1);
      rd_byte(1'b1, d);    check("t3_rd", {8'd0, d}, 16'h00);
      i2c_stop();
      check("t3_idle", {15'd0, busy}, 16'h0);

      // Pointer wrap 0x0F -> 0x00
      i2c_start();
      wr_byte(8'h96, ack);
      wr_byte(8'h0F, ack); check("t4_ack_p", {15'd0, ack}, 16'h0);
      i2c_start();
      wr_byte(8'h97, ack);
      rd_byte(1'b0, d);    check("t4_rd_f", {8'd0, d}, 16'h00);
      rd_byte(1'b1, d);    check("t4_rd_0", {8'd0, d}, 16'h0D);
      i2c_stop();

      // Reset while the target drives a 0 bit
      temp_data = 16'h0C80;
      i2c_start();
      wr_byte(8'h96, ack);
      wr_byte(8'h00, ack);
      i2c_start();
      wr_byte(8'h97, ack);
      check("t5_drive", {15'd0, sda_oe}, 16'h1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("t5_oe",   {15'd0, sda_oe}, 16'h0);
      check("t5_busy", {15'd0, busy},   16'h0);
      check("t5_cfg",  {8'd0, config_reg}, 16'h00);
      @(negedge clk);
      rst = 1'b1;
      qw();
      wr_byte(8'h96, ack); check("t5_quiet", {15'd0, ack}, 16'h1);
      check("t5_busy2", {15'd0, busy}, 16'h0);
      i2c_stop();
      i2c_start();
      wr_byte(8'h96, ack); check("t5_ack_w", {15'd0, ack}, 16'h0);
      wr_byte(8'h03, ack);
      i2c_start();
      wr_byte(8'h97, ack);
      rd_byte(1'b1, d);    check("t5_cfg_rd", {8'd0, d}, 16'h00);
      i2c_stop();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
